and_gate_vector_sequencer: RTL and testbench
============================================

# and_gate_vector_sequencer

Self-checking stimulus/response stage for the 2-input AND gate block (a, b -> c). It drives every input combination into the gate exhaustively, holds each vector for a programmable settle time, samples the gate output, and compares it against the expected AND result. It also counts mismatches and reports pass/fail. It replaces hand-timed `#100` stimulus with a clocked, synthesizable sequencer that can also run on the board.

## Interface
- `N_IN`, default 2: number of gate inputs; 2^N_IN vectors are applied.
- `HOLD_CYCLES`, default 10: clock cycles each vector is held before sampling; legal range ≥1.
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `start`, input, 1: begin a run; sampled only in IDLE.
- `vec`, output, N_IN: stimulus to the gate; bit 0 = `a`, bit 1 = `b`.
- `dut_out`, input, 1: gate output `c`.
- `busy`, output, 1: run in progress.
- `done`, output, 1: one-cycle pulse at run end.
- `pass`, output, 1: last completed run had zero mismatches.
- `err_count`, output, N_IN+1: mismatches in the current or last run.
- `fail_vec`, output, N_IN: first failing vector (only with `AGVS_FAIL_CAPTURE_EN`).
- `fail_valid`, output, 1: `fail_vec` is meaningful (only with `AGVS_FAIL_CAPTURE_EN`).

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start`=1. On entry: `vec`=0, hold counter=0, `err_count`=0, `pass`=0, `fail_valid`=0.
- RUN: hold counter increments each cycle. When it reaches HOLD_CYCLES-1:
  - Sample `dut_out` and compare with the reduction AND of `vec`. On mismatch, `err_count` increments.
  - If `vec` is all-ones, go to DONE. Otherwise increment `vec` and clear the counter.
- DONE, one cycle: `done`=1, `busy`=0, `pass`=(`err_count`==0). Then return to IDLE.
- `vec` holds its last value (all-ones) in IDLE until the next run. `pass`, `err_count` and fail capture hold until the next `start`.
- `err_count` width is N_IN+1, so the maximum value 2^N_IN cannot overflow and no saturation is needed.
- `start` during RUN or DONE is ignored. No queuing.
- The comparison and counter update happen in the same cycle. If the mismatch is on the last vector, it is already included in the `pass` computed in DONE.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_valid`=0, state IDLE.
- Reset mid-run aborts immediately to reset values. No `done` pulse is produced.
- Registered at the edge that samples `start`: state=RUN, `busy`=1, `vec`=0.
- Each vector is valid for exactly HOLD_CYCLES cycles. `dut_out` is sampled at the final edge of that window.
- `done` rises N_IN_VECTORS·HOLD_CYCLES + 1 edges after the `start` sample edge, where N_IN_VECTORS = 2^N_IN. With N_IN=2, HOLD_CYCLES=4, that is 17 edges.
- `busy` falls in the same cycle that `done` rises.
- `dut_out` is treated as combinational from `vec`. HOLD_CYCLES=1 samples on the first edge after `vec` changes.

## Configuration
- `AGVS_FAIL_CAPTURE_EN` defined:
  - `fail_vec` and `fail_valid` ports exist.
  - On the first mismatch of a run, `fail_vec` latches the current `vec` and `fail_valid`=1.
  - Later mismatches do not overwrite the capture.
- Not defined: ports and logic are absent. All other behaviour is identical.

## Structure
- Shared header `and_gate_test_defs.vh` holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default HOLD_CYCLES constant;
  - the expected-function macro (reduction AND).
- One natural sub-module, `hold_counter`: a parameterised modulo-HOLD_CYCLES counter with clear and a terminal-count output, reused by later gate sequencers.

## Test plan
All cases use N_IN=2, HOLD_CYCLES=4 unless stated.

- Correct AND gate, pulse `start` -> `vec` steps 00,01,10,11 at 4 cycles each; `done` after 17 edges; `pass`=1; `err_count`=0; `fail_valid`=0.
- `dut_out` stuck at 0 -> `err_count`=1, `pass`=0, `fail_vec`=11.
- `dut_out` stuck at 1 -> `err_count`=3, `pass`=0, `fail_vec`=00 (not overwritten by 01 or 10).
- OR gate as DUT -> `err_count`=2, `fail_vec`=01.
- `start` re-pulsed at cycle 6 of a run, and `rst_n` dropped at cycle 9 of a second run:
  - re-pulse: no effect on sequence or timing;
  - reset: all outputs at reset values, no `done` pulse, and a fresh `start` completes normally.
- HOLD_CYCLES=1, N_IN=3, correct 3-input AND -> 8 vectors, `done` after 9 edges, `pass`=1.

Source files
------------

// File: rtl/and_gate_vector_sequencer_pkg.sv
// Shared definitions for the AND-gate vector sequencer family:
// state encodings, default hold time and the expected gate function.
package and_gate_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } agvs_state_e;

    localparam int unsigned HOLD_CYCLES_DEFAULT = 10;

    // Reduction AND over the low n bits of v.
    function automatic logic expected_out(
        input logic [31:0] v,
        input int          n
    );
        logic r;
        r = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < n) r = r & v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/and_gate_vector_sequencer_hold_counter.sv
// hold_counter: modulo-HOLD_CYCLES counter with synchronous clear
// and a terminal-count flag on the last count of the window.
module hold_counter
    import and_gate_vector_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW =
        (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/and_gate_vector_sequencer.sv
// Exhaustive stimulus/response sequencer for an N_IN-input AND gate.
// Optional first-failure capture: define AGVS_FAIL_CAPTURE_EN.
module and_gate_vector_sequencer
    import and_gate_vector_sequencer_pkg::*;
#(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    output logic [N_IN-1:0] vec_o,
    input  logic            dut_out_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
`ifdef AGVS_FAIL_CAPTURE_EN
    output logic [N_IN-1:0] fail_vec_o,
    output logic            fail_valid_o,
`endif
    output logic [N_IN:0]   err_count_o
);

    agvs_state_e     state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_tc;
    logic            mismatch;
`ifdef AGVS_FAIL_CAPTURE_EN
    logic [N_IN-1:0] fvec_q, fvec_d;
    logic            fval_q, fval_d;
`endif

    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    assign mismatch =
        dut_out_i != expected_out(32'(vec_q), int'(N_IN));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef AGVS_FAIL_CAPTURE_EN
        fvec_d  = fvec_q;
        fval_d  = fval_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    cnt_clr = 1'b1;
`ifdef AGVS_FAIL_CAPTURE_EN
                    fval_d  = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
`ifdef AGVS_FAIL_CAPTURE_EN
                        if (!fval_q) begin
                            fvec_d = vec_q;
                            fval_d = 1'b1;
                        end
`endif
                    end
                    // Counter wraps to zero by itself at terminal count.
                    if (&vec_q) state_d = ST_DONE;
                    else        vec_d   = vec_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef AGVS_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fvec_q <= '0;
            fval_q <= 1'b0;
        end else begin
            fvec_q <= fvec_d;
            fval_q <= fval_d;
        end
    end

    assign fail_vec_o   = fvec_q;
    assign fail_valid_o = fval_q;
`endif

    assign vec_o       = vec_q;
    assign err_count_o = err_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;

endmodule

// File: tb/tb_and_gate_vector_sequencer.sv
// Randomised self-checking bench for and_gate_vector_sequencer.
// Fail-capture checks are included when AGVS_FAIL_CAPTURE_EN is defined.
module tb_and_gate_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic       start_a = 1'b0;
    logic [1:0] vec_a;
    logic       dout_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic       start_b = 1'b0;
    logic [2:0] vec_b;
    logic       dout_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] err_b;
`ifdef AGVS_FAIL_CAPTURE_EN
    logic [1:0] fvec_a;
    logic       fval_a;
    logic [2:0] fvec_b;
    logic       fval_b;
`endif

    // Gate behaviour: 0 AND, 1 stuck0, 2 stuck1, 3 OR, 4 AND^mask
    int         mode_a = 0;
    logic [7:0] mask_a = '0;

    function automatic logic gate_model(
        input int mode, input logic [7:0] mask,
        input int v, input int n);
        int top;
        top = (1 << n) - 1;
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v != 0;
            4:       return (v == top) ^ mask[v];
            default: return v == top;
        endcase
    endfunction

    always_comb dout_a = gate_model(mode_a, mask_a, int'(vec_a), 2);
    always_comb dout_b = (int'(vec_b) == 7);

    and_gate_vector_sequencer #(.N_IN(2), .HOLD_CYCLES(4)) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_a),
        .vec_o        (vec_a),
        .dut_out_i    (dout_a),
        .busy_o       (busy_a),
        .done_o       (done_a),
        .pass_o       (pass_a),
`ifdef AGVS_FAIL_CAPTURE_EN
        .fail_vec_o   (fvec_a),
        .fail_valid_o (fval_a),
`endif
        .err_count_o  (err_a)
    );

    and_gate_vector_sequencer #(.N_IN(3), .HOLD_CYCLES(1)) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_b),
        .vec_o        (vec_b),
        .dut_out_i    (dout_b),
        .busy_o       (busy_b),
        .done_o       (done_b),
        .pass_o       (pass_b),
`ifdef AGVS_FAIL_CAPTURE_EN
        .fail_vec_o   (fvec_b),
        .fail_valid_o (fval_b),
`endif
        .err_count_o  (err_b)
    );

    int vec_tr[64];
    bit busy_tr[64];
    int done_edge;

    // Start DUT A and record vec/busy after every edge.
    task automatic run_a(input int repulse_at, input int reset_at);
        done_edge = -1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        vec_tr[0] = int'(vec_a);
        busy_tr[0] = busy_a;
        for (int k = 1; k <= 40; k++) begin
            if (k == repulse_at) start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            vec_tr[k] = int'(vec_a);
            busy_tr[k] = busy_a;
            if (k == reset_at) begin
                rst_n = 1'b0;
                break;
            end
            if (done_a) begin
                done_edge = k;
                break;
            end
        end
    endtask

    // Cycles where the recorded trace departs from the ideal schedule.
    function automatic int trace_errs(input int n_vec, input int hold);
        int bad;
        int ev;
        bad = 0;
        for (int k = 0; k <= n_vec * hold + 1; k++) begin
            ev = k / hold;
            if (ev > n_vec - 1) ev = n_vec - 1;
            if (vec_tr[k] != ev) bad++;
            if (busy_tr[k] != (k <= n_vec * hold)) bad++;
        end
        return bad;
    endfunction

    // Reference: count vectors where the gate differs from full AND.
    task automatic model_a(output int e, output int first);
        e = 0;
        first = -1;
        for (int v = 0; v < 4; v++) begin
            if (gate_model(mode_a, mask_a, v, 2) != (v == 3)) begin
                e++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({vec_a, busy_a, done_a, pass_a, err_a} !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_a: got %h want 0",
                     {vec_a, busy_a, done_a, pass_a, err_a});
        end
        tests_run++;
        if ({vec_b, busy_b, done_b, pass_b, err_b} !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset_b: got %h want 0",
                     {vec_b, busy_b, done_b, pass_b, err_b});
        end
`ifdef AGVS_FAIL_CAPTURE_EN
        tests_run++;
        if ({fvec_a, fval_a} !== 3'h0) begin
            tests_failed++;
            $display("FAIL reset_fail: got %h want 0", {fvec_a, fval_a});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_correct_and();
        mode_a = 0;
        run_a(-1, -1);
        tests_run++;
        if (done_edge != 17) begin
            tests_failed++;
            $display("FAIL and_done_edge: got %0d want 17", done_edge);
        end
        tests_run++;
        if (done_edge == 17 && trace_errs(4, 4) != 0 || done_edge != 17) begin
            tests_failed++;
            $display("FAIL and_trace: bad cycles %0d want 0",
                     trace_errs(4, 4));
        end
        tests_run++;
        if (pass_a !== 1'b1 || err_a !== 3'd0) begin
            tests_failed++;
            $display("FAIL and_result: pass %b err %0d want 1 0",
                     pass_a, err_a);
        end
`ifdef AGVS_FAIL_CAPTURE_EN
        tests_run++;
        if (fval_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL and_fail_valid: got %b want 0", fval_a);
        end
`endif
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (done_a !== 1'b0 || vec_a !== 2'b11 || pass_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_hold: done %b vec %b pass %b want 0 11 1",
                     done_a, vec_a, pass_a);
        end
    endtask

    task automatic check_fault_run(input string name);
        int e;
        int first;
        model_a(e, first);
        run_a(-1, -1);
        tests_run++;
        if (done_edge != 17 || int'(err_a) != e || pass_a !== (e == 0)) begin
            tests_failed++;
            $display("FAIL %s: edge %0d err %0d pass %b want 17 %0d %b",
                     name, done_edge, err_a, pass_a, e, e == 0);
        end
`ifdef AGVS_FAIL_CAPTURE_EN
        tests_run++;
        if (fval_a !== (e != 0) || (e != 0 && int'(fvec_a) != first)) begin
            tests_failed++;
            $display("FAIL %s_capture: valid %b vec %0d want %b %0d",
                     name, fval_a, fvec_a, e != 0, first);
        end
`endif
    endtask

    task automatic test_fixed_faults();
        mode_a = 1;
        check_fault_run("stuck0");
        mode_a = 2;
        check_fault_run("stuck1");
        mode_a = 3;
        check_fault_run("or_gate");
    endtask

    task automatic test_random_faults();
        mode_a = 4;
        for (int i = 0; i < 8; i++) begin
            mask_a = 8'($urandom_range(0, 15));
            check_fault_run($sformatf("rand_mask_%h", mask_a));
        end
        mode_a = 0;
        mask_a = '0;
    endtask

    task automatic test_repulse_reset();
        int dn;
        mode_a = 2;
        run_a(6, -1);
        tests_run++;
        if (done_edge != 17 || trace_errs(4, 4) != 0 || err_a !== 3'd3) begin
            tests_failed++;
            $display("FAIL repulse: edge %0d err %0d want 17 3",
                     done_edge, err_a);
        end
        run_a(-1, 9);
        #1;
        tests_run++;
        if ({vec_a, busy_a, done_a, pass_a, err_a} !== 8'h0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got %h want 0",
                     {vec_a, busy_a, done_a, pass_a, err_a});
        end
        dn = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a) dn++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_a) dn++;
        end
        tests_run++;
        if (dn != 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d pulses want 0", dn);
        end
        mode_a = 0;
        run_a(-1, -1);
        tests_run++;
        if (done_edge != 17 || pass_a !== 1'b1 || err_a !== 3'd0) begin
            tests_failed++;
            $display("FAIL post_reset_run: edge %0d pass %b err %0d",
                     done_edge, pass_a, err_a);
        end
    endtask

    task automatic test_n3_hold1();
        done_edge = -1;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        vec_tr[0] = int'(vec_b);
        busy_tr[0] = busy_b;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            vec_tr[k] = int'(vec_b);
            busy_tr[k] = busy_b;
            if (done_b) begin
                done_edge = k;
                break;
            end
        end
        tests_run++;
        if (done_edge != 9 || trace_errs(8, 1) != 0) begin
            tests_failed++;
            $display("FAIL n3_timing: edge %0d bad %0d want 9 0",
                     done_edge, trace_errs(8, 1));
        end
        tests_run++;
        if (pass_b !== 1'b1 || err_b !== 4'd0) begin
            tests_failed++;
            $display("FAIL n3_result: pass %b err %0d want 1 0",
                     pass_b, err_b);
        end
    endtask

    initial begin
        test_reset();
        test_correct_and();
        test_fixed_faults();
        test_random_faults();
        test_repulse_reset();
        test_n3_hold1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
